// File: rtl/fetch_step_unit.sv
// PC register, next-PC selection and step/run pacing FSM producing a one-cycle cpu_en.
// Optional breakpoint halt is compiled in with FETCH_BRKPT_EN.
module fetch_step_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEB_CYC  = 500000,
    parameter int              RUN_DIV  = 50000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            step_n,
    input  logic            run_sw,
    input  logic            branch,
    input  logic            zero,
    input  logic            jump,
    input  logic [PC_W-1:0] imm,
    input  logic [PC_W-1:0] jaddr,
    input  logic [PC_W-1:0] brk_addr,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus1,
    output logic            cpu_en,
    output logic            running,
    output logic [15:0]     instr_cnt,
    output logic            brk_hit
);

    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    // Handshake: cpu_en is a valid-only strobe with no ready; downstream must
    // commit its write in exactly the cycle cpu_en is high.
    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_READY = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              step_meta_q, step_meta_d;
    logic              step_sync_q, step_sync_d;
    logic              run_meta_q, run_meta_d;
    logic              run_sync_q, run_sync_d;
    logic              deb_level_q, deb_level_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              step_evt_q, step_evt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       instr_cnt_q, instr_cnt_d;
    logic              run_tick;
    logic              halted;
    logic              step_ok;
    logic              tick_ok;
    logic [PC_W-1:0]   next_pc;

`ifdef FETCH_BRKPT_EN
    logic              brk_hit_q, brk_hit_d;
`else
    logic              unused_brk_addr;
    assign unused_brk_addr = ^brk_addr;
`endif

    // Input conditioning: synchronizers, debounce and run divider.
    always_comb begin
        step_meta_d = step_n;
        step_sync_d = step_meta_q;
        run_meta_d  = run_sw;
        run_sync_d  = run_meta_q;

        deb_level_d = deb_level_q;
        deb_cnt_d   = '0;
        if (step_sync_q != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = step_sync_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
        // One pulse per accepted press (released -> pressed).
        step_evt_d = deb_level_q & ~deb_level_d;

        run_tick  = 1'b0;
        div_cnt_d = '0;
        if (run_sync_q) begin
            if (div_cnt_q == DIV_LAST) begin
                run_tick = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    assign pc_plus1 = pc_q + PC_W'(1);

    always_comb begin
        next_pc = pc_plus1;
        if (jump) begin
            next_pc = jaddr;
        end else if (branch && zero) begin
            next_pc = pc_plus1 + imm;
        end
    end

    // Pacing FSM plus PC / instruction counter updates.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_cnt_d = instr_cnt_q;
        cpu_en      = 1'b0;
        halted      = 1'b0;

`ifdef FETCH_BRKPT_EN
        brk_hit_d = brk_hit_q;
        if (state_q == S_READY && run_sync_q && pc_q == brk_addr) begin
            brk_hit_d = 1'b1;
        end
        if (!run_sync_q) begin
            brk_hit_d = 1'b0;
        end
        // A hit in this very cycle must already block the tick.
        halted = brk_hit_d;
`endif

        // Step presses only count in single-step mode or while parked at a breakpoint.
        step_ok = step_evt_q & (~run_sync_q | halted);
        tick_ok = run_tick & ~halted;

        case (state_q)
            S_WAIT: begin
                state_d = S_READY;
            end
            S_READY: begin
                if (step_ok || tick_ok) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                cpu_en      = 1'b1;
                pc_d        = next_pc;
                instr_cnt_d = instr_cnt_q + 16'd1;
                state_d     = S_WAIT;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_WAIT;
            step_meta_q <= 1'b1;
            step_sync_q <= 1'b1;
            run_meta_q  <= 1'b0;
            run_sync_q  <= 1'b0;
            deb_level_q <= 1'b1;
            deb_cnt_q   <= '0;
            step_evt_q  <= 1'b0;
            div_cnt_q   <= '0;
            pc_q        <= RESET_PC;
            instr_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            step_meta_q <= step_meta_d;
            step_sync_q <= step_sync_d;
            run_meta_q  <= run_meta_d;
            run_sync_q  <= run_sync_d;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            step_evt_q  <= step_evt_d;
            div_cnt_q   <= div_cnt_d;
            pc_q        <= pc_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

`ifdef FETCH_BRKPT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            brk_hit_q <= 1'b0;
        end else begin
            brk_hit_q <= brk_hit_d;
        end
    end
    assign brk_hit = brk_hit_q;
`else
    assign brk_hit = 1'b0;
`endif

    assign pc        = pc_q;
    assign instr_cnt = instr_cnt_q;
    assign running   = run_sync_q & ~brk_hit;

endmodule

// File: tb/tb_fetch_step_unit.sv
// Bench for fetch_step_unit: directed and random steps, run mode pacing, mid-op reset,
// and the breakpoint halt when built with FETCH_BRKPT_EN.
module tb_fetch_step_unit;

    localparam int PC_W    = 8;
    localparam int DEB_CYC = 4;
    localparam int RUN_DIV = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            step_n;
    logic            run_sw;
    logic            branch;
    logic            zero;
    logic            jump;
    logic [PC_W-1:0] imm;
    logic [PC_W-1:0] jaddr;
    logic [PC_W-1:0] brk_addr;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus1;
    logic            cpu_en;
    logic            running;
    logic [15:0]     instr_cnt;
    logic            brk_hit;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int strobes    = 0;
    int st_q[$];
    int pc_model   = 0;
    int cnt_model  = 0;

    fetch_step_unit #(
        .PC_W    (PC_W),
        .RESET_PC(8'h00),
        .DEB_CYC (DEB_CYC),
        .RUN_DIV (RUN_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .step_n   (step_n),
        .run_sw   (run_sw),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .imm      (imm),
        .jaddr    (jaddr),
        .brk_addr (brk_addr),
        .pc       (pc),
        .pc_plus1 (pc_plus1),
        .cpu_en   (cpu_en),
        .running  (running),
        .instr_cnt(instr_cnt),
        .brk_hit  (brk_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and log any execute strobe seen there.
    task automatic clk_cycle();
        @(negedge clk);
        cyc++;
        if (cpu_en === 1'b1) begin
            strobes++;
            st_q.push_back(cyc);
        end
    endtask

    task automatic press(input int low_len, input int high_len);
        step_n = 1'b0;
        repeat (low_len) clk_cycle();
        step_n = 1'b1;
        repeat (high_len) clk_cycle();
    endtask

    // Architectural next-PC rule, on plain integers.
    function automatic int ref_next_pc(input int cur, input bit j, input bit b, input bit z,
                                       input int off8, input int target);
        int off;
        off = (off8 >= 128) ? off8 - 256 : off8;
        if (j) return target & 255;
        if (b && z) return (cur + 1 + off) & 255;
        return (cur + 1) & 255;
    endfunction

    task automatic do_step(input bit j, input bit b, input bit z, input int off, input int tgt);
        int s0;
        int exp_pc;
        jump   = j;
        branch = b;
        zero   = z;
        imm    = off[7:0];
        jaddr  = tgt[7:0];
        exp_pc = ref_next_pc(pc_model, j, b, z, off, tgt);
        s0     = strobes;
        press(10, 12);
        check("step_strobes", strobes - s0, 1);
        pc_model  = exp_pc;
        cnt_model = (cnt_model + 1) & 16'hFFFF;
        check("step_pc", pc, pc_model);
        check("step_cnt", instr_cnt, cnt_model);
        check("step_pc_plus1", pc_plus1, (pc_model + 1) & 255);
    endtask

    initial begin
        int s0;
        int c0;
        int guard;
        rst      = 1'b1;
        step_n   = 1'b1;
        run_sw   = 1'b0;
        branch   = 1'b0;
        zero     = 1'b0;
        jump     = 1'b0;
        imm      = '0;
        jaddr    = '0;
        brk_addr = 8'hAA;

        // Reset
        clk_cycle();
        check("rst_pc", pc, 0);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_running", running, 0);
        check("rst_cnt", instr_cnt, 0);
        check("rst_brk_hit", brk_hit, 0);
        rst = 1'b0;
        clk_cycle();
        check("post_rst_cpu_en_1", cpu_en, 0);
        clk_cycle();
        check("post_rst_cpu_en_2", cpu_en, 0);
        repeat (5) clk_cycle();

        // Short glitches must not register; the following full press counts once.
        s0 = strobes;
        repeat (3) begin
            step_n = 1'b0;
            clk_cycle();
            step_n = 1'b1;
            repeat (2) clk_cycle();
        end
        press(10, 12);
        check("glitch_strobes", strobes - s0, 1);
        pc_model  = 1;
        cnt_model = 1;
        check("glitch_pc", pc, 1);
        check("glitch_cnt", instr_cnt, 1);

        // Directed next-PC cases.
        do_step(1, 0, 0, 0, 8'h05);
        do_step(0, 1, 1, 8'hFC, 0);
        check("branch_taken_pc", pc, 8'h02);
        do_step(1, 0, 0, 0, 8'h05);
        do_step(0, 1, 0, 8'hFC, 0);
        check("branch_not_taken_pc", pc, 8'h06);
        do_step(1, 1, 1, 8'h10, 8'h40);
        check("jump_wins_pc", pc, 8'h40);
        do_step(1, 0, 0, 0, 8'hFF);
        check("pc_plus1_wrap", pc_plus1, 8'h00);
        do_step(0, 0, 0, 0, 0);
        check("pc_wrap", pc, 8'h00);

        // Random steps against the reference rule.
        repeat (12) begin
            do_step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        // Run mode with a step press that must be ignored.
        jump   = 1'b0;
        branch = 1'b0;
        zero   = 1'b0;
`ifdef FETCH_BRKPT_EN
        brk_addr = 8'((pc_model + 100) & 255);
`else
        brk_addr = 8'((pc_model + 3) & 255);
`endif
        st_q.delete();
        s0     = strobes;
        c0     = cyc;
        run_sw = 1'b1;
        for (int i = 1; i <= 84; i++) begin
            clk_cycle();
            if (i == 20) step_n = 1'b0;
            if (i == 32) step_n = 1'b1;
            if (i == 40) check("run_running", running, 1);
        end
        check("run_strobes", strobes - s0, 10);
        if (st_q.size() > 0) check("run_first_strobe", st_q[0] - c0, 2 + RUN_DIV);
        for (int k = 1; k < st_q.size(); k++) begin
            check("run_gap", st_q[k] - st_q[k-1], RUN_DIV);
        end
        pc_model  = (pc_model + 10) & 255;
        cnt_model = (cnt_model + 10) & 16'hFFFF;
        check("run_pc", pc, pc_model);
        check("run_cnt", instr_cnt, cnt_model);
        check("run_no_brk", brk_hit, 0);
        s0     = strobes;
        run_sw = 1'b0;
        repeat (20) clk_cycle();
        check("stop_strobes", strobes - s0, 0);
        check("stop_running", running, 0);

        // Reset while a press is pending must abort the strobe.
        step_n = 1'b0;
        repeat (6) clk_cycle();
        rst    = 1'b1;
        step_n = 1'b1;
        s0     = strobes;
        clk_cycle();
        check("midrst_cpu_en", cpu_en, 0);
        check("midrst_pc", pc, 0);
        check("midrst_cnt", instr_cnt, 0);
        rst = 1'b0;
        repeat (20) clk_cycle();
        check("midrst_strobes", strobes - s0, 0);
        pc_model  = 0;
        cnt_model = 0;

`ifdef FETCH_BRKPT_EN
        // Breakpoint: run halts at brk_addr, single step still advances, toggle resumes.
        brk_addr = 8'h03;
        s0       = strobes;
        run_sw   = 1'b1;
        guard    = 0;
        while (brk_hit !== 1'b1 && guard < 200) begin
            clk_cycle();
            guard++;
        end
        check("brk_strobes_to_halt", strobes - s0, 3);
        s0 = strobes;
        repeat (30) clk_cycle();
        check("brk_halt_strobes", strobes - s0, 0);
        check("brk_halt_pc", pc, 3);
        check("brk_halt_flag", brk_hit, 1);
        check("brk_halt_running", running, 0);
        s0 = strobes;
        press(10, 12);
        check("brk_step_strobes", strobes - s0, 1);
        check("brk_step_pc", pc, 4);
        check("brk_step_flag", brk_hit, 1);
        run_sw = 1'b0;
        repeat (5) clk_cycle();
        check("brk_clear", brk_hit, 0);
        s0     = strobes;
        run_sw = 1'b1;
        repeat (30) clk_cycle();
        check("brk_resume", (strobes - s0) > 0, 1);
        check("brk_resume_running", running, 1);
        run_sw = 1'b0;
        repeat (10) clk_cycle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
